instr_exec_ctrl: RTL and testbench
==================================

Name: instr_exec_ctrl

Overview:
- Multi-cycle decode/execute/write-back controller that sits directly upstream of the 4x8-bit register file in the microprocessor datapath.
- Accepts one 8-bit instruction at a time from the fetch unit over a valid/ready handshake.
- Drives the register-file read/write addresses, computes the result from the combinational read data, and issues one write-back pulse. Jump instructions are returned to fetch as a redirect.

Parameters:
- DATA_W, 8, datapath and instruction width.
- RA_W, 2, register address width (4 registers).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- instr_valid  input  1  fetch presents a valid instruction.
- instr  input  DATA_W  instruction word.
- instr_ready  output  1  controller can accept an instruction.
- rs  output  RA_W  register-file read address 1.
- rt  output  RA_W  register-file read address 2.
- rd  output  RA_W  register-file write address.
- writeData  output  DATA_W  write-back data.
- RegWrite  output  1  one-cycle write-enable pulse.
- readData1  input  DATA_W  register-file data at rs (combinational).
- readData2  input  DATA_W  register-file data at rt (combinational).
- jump_valid  output  1  one-cycle redirect pulse to fetch.
- jump_offset  output  DATA_W  signed PC offset, valid while jump_valid=1.
- ovf  output  1  sticky signed-overflow flag.
- retired  output  8  retired-instruction counter.

Behaviour:
- ISA, IR=captured instruction: op=IR[7:6], a=IR[5:4], b=IR[3:2], c=IR[1:0].
  - op 00 ADD: R[c] = R[a] + R[b].
  - op 01 ADDI: R[b] = R[a] + sext(c).
  - op 10 SUB: R[c] = R[a] - R[b].
  - op 11 JMP: offset = sext(IR[5:0]); no register write.
- Address outputs: rs=IR[5:4], rt=IR[3:2]. rd=IR[1:0] for ADD/SUB, IR[3:2] for ADDI.
- States:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, IR<=instr; go to EXEC if op!=11, otherwise JUMP.
  - EXEC: result<=ALU(readData1, readData2 or sext(c)), truncated to DATA_W. ovf<=ovf | signed overflow (operands same sign and result sign differs for ADD/ADDI; operands differ in sign and result sign differs from a for SUB). Go to WB.
  - WB: RegWrite=1, writeData=result, retired<=retired+1; go to IDLE.
  - JUMP: jump_valid=1, retired<=retired+1; go to IDLE.
- Latency:
  - Accept at edge E0, EXEC in cycle 1, RegWrite in cycle 2, instr_ready=1 again in cycle 3. Throughput is one ALU op per 3 cycles.
  - JMP: jump_valid in cycle 1, ready again in cycle 2.
- instr_ready=0 in EXEC, WB and JUMP. instr_valid in those states is ignored, and fetch must hold it.
- No read-after-write hazard: the next instruction is accepted only after the WB edge has written the register file.
- writeData=result in every state. RegWrite and jump_valid are 0 outside WB and JUMP respectively.
- retired wraps 0xFF->0x00. ovf is cleared only by reset.
- Reset (reset=0 at an edge), including mid-instruction:
  - state=IDLE; IR, result, retired and ovf are 0.
  - Any pending write-back or jump is dropped.
  - instr_ready is forced to 0 while reset=0.
  - Outputs during/after reset: rs=rt=rd=0, writeData=0, RegWrite=0, jump_valid=0, jump_offset=0.

Decomposition:
- Shared package: opcode constants OP_ADD/OP_ADDI/OP_SUB/OP_JMP, state encoding, DATA_W/RA_W defaults.
- One natural sub-module, alu8: combinational add/sub with overflow output, reused by the later branch unit.

Test Plan:
- Reset mid-WB: reset=0 during RegWrite cycle -> RegWrite=0 the next cycle, retired=0, ovf=0, instr_ready=1 one cycle after reset=1.
- ADD: instr=0x1B (r1+r2->r3), readData1=0x05, readData2=0x03 -> rs=1, rt=2; RegWrite pulses cycle 2 with rd=3, writeData=0x08; retired=1.
- ADDI negative immediate: instr=0x47 (r1 = r0 + sext(2'b11)), readData1=0x00 -> rd=1, writeData=0xFF, ovf=0.
- SUB overflow: instr=0x9B, readData1=0x80, readData2=0x01 -> writeData=0x7F, ovf=1. A following ADD 0x01+0x01 -> ovf stays 1.
- JMP: instr=0xFC (offset -4) -> jump_valid=1 for exactly one cycle with jump_offset=0xFC, RegWrite stays 0, ready back in cycle 2.
- Handshake/wrap: instr_valid held high with back-to-back instructions -> exactly one accept per IDLE cycle. 256 retirements -> retired wraps to 0x00.

Source files
------------

// File: rtl/instr_exec_ctrl_pkg.sv
// rtl/instr_exec_ctrl_pkg.sv - shared opcodes, state encoding and width defaults
package instr_exec_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int RA_W_DEF   = 2;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_JMP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10,
        ST_JUMP = 2'b11
    } state_e;

endpackage

// File: rtl/instr_exec_ctrl_alu8.sv
// rtl/instr_exec_ctrl_alu8.sv - combinational add/sub with signed overflow
module alu8
    import instr_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] b_eff;

    // Subtraction as a + ~b + 1, so one sign rule covers both operations.
    assign b_eff = sub_i ? ~b_i : b_i;
    assign sum_o = a_i + b_eff + {{(DATA_W-1){1'b0}}, sub_i};
    assign ovf_o = (a_i[DATA_W-1] == b_eff[DATA_W-1]) &&
                   (sum_o[DATA_W-1] != a_i[DATA_W-1]);

endmodule

// File: rtl/instr_exec_ctrl.sv
// rtl/instr_exec_ctrl.sv - decode/execute/write-back controller ahead of the 4x8 register file
module instr_exec_ctrl
    import instr_exec_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    output logic              instr_ready,
    output logic [RA_W-1:0]   rs,
    output logic [RA_W-1:0]   rt,
    output logic [RA_W-1:0]   rd,
    output logic [DATA_W-1:0] writeData,
    output logic              RegWrite,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    output logic              jump_valid,
    output logic [DATA_W-1:0] jump_offset,
    output logic              ovf,
    output logic [7:0]        retired
);

    state_e            state_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] result_q;
    logic [7:0]        retired_q;
    logic              ovf_q;

    logic [1:0]        op;
    logic [DATA_W-1:0] imm_c;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_sum;
    logic              alu_ovf;

    assign op    = ir_q[7:6];
    assign imm_c = {{(DATA_W-2){ir_q[1]}}, ir_q[1:0]};
    assign alu_b = (op == OP_ADDI) ? imm_c : readData2;

    alu8 #(.DATA_W(DATA_W)) u_alu (
        .a_i   (readData1),
        .b_i   (alu_b),
        .sub_i (op == OP_SUB),
        .sum_o (alu_sum),
        .ovf_o (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            result_q  <= '0;
            retired_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        state_q <= (instr[7:6] == OP_JMP) ? ST_JUMP : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_sum;
                    ovf_q    <= ovf_q | alu_ovf;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    retired_q <= retired_q + 8'd1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    retired_q <= retired_q + 8'd1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Every output is held at its reset value while reset is low, so a
    // write-back or redirect in flight is suppressed immediately.
    assign instr_ready = reset && (state_q == ST_IDLE);
    assign RegWrite    = reset && (state_q == ST_WB);
    assign jump_valid  = reset && (state_q == ST_JUMP);
    assign rs          = reset ? ir_q[5:4] : '0;
    assign rt          = reset ? ir_q[3:2] : '0;
    assign rd          = !reset ? '0 : (op == OP_ADDI) ? ir_q[3:2] : ir_q[1:0];
    assign writeData   = reset ? result_q : '0;
    assign jump_offset = reset ? {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]} : '0;
    assign ovf         = ovf_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// tb/tb_instr_exec_ctrl.sv - directed self-checking bench for instr_exec_ctrl
module tb_instr_exec_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [1:0] rs, rt, rd;
    logic [7:0] writeData;
    logic       RegWrite;
    logic [7:0] readData1, readData2;
    logic       jump_valid;
    logic [7:0] jump_offset;
    logic       ovf;
    logic [7:0] retired;

    int vectors    = 0;
    int miscompares = 0;
    int accepts;

    instr_exec_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .writeData   (writeData),
        .RegWrite    (RegWrite),
        .readData1   (readData1),
        .readData2   (readData2),
        .jump_valid  (jump_valid),
        .jump_offset (jump_offset),
        .ovf         (ovf),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        readData1   = 8'h00;
        readData2   = 8'h00;
        tick();
        tick();
        check("rst_ready", instr_ready, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_jump", jump_valid, 0);
        check("rst_retired", retired, 0);
        check("rst_ovf", ovf, 0);
        check("rst_wdata", writeData, 0);
        reset = 1'b1;
        tick();
        check("rst_ready_after", instr_ready, 1);

        // SUB overflow: 0x80 - 0x01
        readData1 = 8'h80; readData2 = 8'h01;
        instr = 8'h9B; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("sub_ready_exec", instr_ready, 0);
        tick();
        check("sub_regwrite", RegWrite, 1);
        check("sub_rd", rd, 3);
        check("sub_wdata", writeData, 8'h7F);
        check("sub_ovf", ovf, 1);
        tick();
        check("sub_retired", retired, 1);
        check("sub_regwrite_off", RegWrite, 0);

        // ADD 1+1 keeps sticky ovf
        readData1 = 8'h01; readData2 = 8'h01;
        instr = 8'h1B; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("add2_wdata", writeData, 8'h02);
        tick();
        check("add2_ovf_sticky", ovf, 1);
        check("add2_retired", retired, 2);

        // reset asserted during the write-back cycle
        instr = 8'h1B; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("rwb_regwrite_pre", RegWrite, 1);
        reset = 1'b0;
        tick();
        check("rwb_regwrite", RegWrite, 0);
        check("rwb_retired", retired, 0);
        check("rwb_ovf", ovf, 0);
        check("rwb_ready_low", instr_ready, 0);
        check("rwb_rs", rs, 0);
        check("rwb_rd", rd, 0);
        check("rwb_wdata", writeData, 0);
        reset = 1'b1;
        tick();
        check("rwb_ready_high", instr_ready, 1);
        check("rwb_regwrite_post", RegWrite, 0);

        // ADD r1+r2 -> r3
        readData1 = 8'h05; readData2 = 8'h03;
        instr = 8'h1B; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("add_rs", rs, 1);
        check("add_rt", rt, 2);
        check("add_regwrite_c1", RegWrite, 0);
        tick();
        check("add_regwrite_c2", RegWrite, 1);
        check("add_rd", rd, 3);
        check("add_wdata", writeData, 8'h08);
        tick();
        check("add_retired", retired, 1);
        check("add_ready_c3", instr_ready, 1);

        // ADDI r1 = r0 + (-1)
        readData1 = 8'h00; readData2 = 8'h55;
        instr = 8'h47; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("addi_rs", rs, 0);
        tick();
        check("addi_rd", rd, 1);
        check("addi_wdata", writeData, 8'hFF);
        check("addi_ovf", ovf, 0);
        tick();
        check("addi_retired", retired, 2);

        // JMP -4
        instr = 8'hFC; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("jmp_valid", jump_valid, 1);
        check("jmp_offset", jump_offset, 8'hFC);
        check("jmp_regwrite", RegWrite, 0);
        check("jmp_ready_c1", instr_ready, 0);
        tick();
        check("jmp_valid_off", jump_valid, 0);
        check("jmp_ready_c2", instr_ready, 1);
        check("jmp_retired", retired, 3);

        // held valid, back-to-back jumps: one accept per IDLE cycle
        accepts = 0;
        instr = 8'hFC; instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid && instr_ready) accepts++;
            tick();
        end
        instr_valid = 1'b0;
        check("b2b_jmp_accepts", accepts, 10);
        check("b2b_jmp_retired", retired, 13);

        // held valid, back-to-back ALU ops: one accept per 3 cycles
        accepts = 0;
        instr = 8'h1B; instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (instr_valid && instr_ready) accepts++;
            tick();
        end
        instr_valid = 1'b0;
        check("b2b_alu_accepts", accepts, 3);
        check("b2b_alu_retired", retired, 16);

        // drive the counter to 0xFF then wrap it
        instr = 8'hFC; instr_valid = 1'b1;
        for (int i = 0; i < 478; i++) tick();
        instr_valid = 1'b0;
        check("wrap_ff", retired, 8'hFF);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("wrap_00", retired, 8'h00);
        check("wrap_ready", instr_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
